// File: rtl/mips_pipeline.sv
// rtl/mips_pipeline.sv - five-stage in-order 32-bit RISC core with unified word-addressed memory
module mips_pipeline (
  input logic clk,
  input logic rst_n
);
  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;

  typedef struct packed {
    logic        valid;
    logic [31:0] ir;
    logic [31:0] npc;
  } ifid_t;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic        wr;
    logic        halt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] npc;
  } idex_t;

  typedef struct packed {
    logic        valid;
    logic        ld;
    logic        st;
    logic        halt;
    logic        wr;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] sd;
  } exmem_t;

  typedef struct packed {
    logic        valid;
    logic        halt;
    logic        wr;
    logic [4:0]  dst;
    logic [31:0] val;
  } memwb_t;

  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:1023];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  logic [31:0] pc_d;
  logic        halted_d, taken_d;
  ifid_t       ifid_q, ifid_d;
  idex_t       idex_q, idex_d;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;

  logic        wb_we, mem_we, older_halt_mem, older_halt_ex, ex_valid, br_taken;
  logic [9:0]  mem_addr;
  logic [31:0] op_a, op_b, alu;
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        is_rr, is_ri, is_lw, is_sw, is_br;

  // Youngest producer wins; a load still in EX/MEM has no data yet, so it is skipped.
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v,
                                      input exmem_t em, input memwb_t mw);
    if (r == 5'd0) return 32'd0;
    if (em.valid && em.wr && !em.ld && em.dst == r) return em.alu;
    if (mw.valid && mw.wr && mw.dst == r) return mw.val;
    return v;
  endfunction

  always_comb begin
    wb_we    = memwb_q.valid & memwb_q.wr & (memwb_q.dst != 5'd0) & ~HALTED;
    halted_d = HALTED | (memwb_q.valid & memwb_q.halt);

    // Anything behind a HLT already in MEM/WB (or EX/MEM) must never commit.
    older_halt_mem = memwb_q.valid & memwb_q.halt;
    mem_addr       = exmem_q.alu[9:0];
    mem_we         = exmem_q.valid & exmem_q.st & ~older_halt_mem & ~HALTED;
    memwb_d        = '0;
    memwb_d.valid  = exmem_q.valid & ~older_halt_mem;
    memwb_d.halt   = exmem_q.halt;
    memwb_d.wr     = exmem_q.wr;
    memwb_d.dst    = exmem_q.dst;
    memwb_d.val    = exmem_q.ld ? Mem[mem_addr] : exmem_q.alu;

    older_halt_ex = (exmem_q.valid & exmem_q.halt) | older_halt_mem;
    ex_valid      = idex_q.valid & ~older_halt_ex;
    op_a          = fwd(idex_q.rs, idex_q.a, exmem_q, memwb_q);
    op_b          = fwd(idex_q.rt, idex_q.b, exmem_q, memwb_q);
    case (idex_q.op)
      OP_ADD:              alu = op_a + op_b;
      OP_SUB:              alu = op_a - op_b;
      OP_AND:              alu = op_a & op_b;
      OP_OR:               alu = op_a | op_b;
      OP_SLT:              alu = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      OP_MUL:              alu = op_a * op_b;
      OP_ADDI, OP_LW, OP_SW: alu = op_a + idex_q.imm;
      OP_SUBI:             alu = op_a - idex_q.imm;
      OP_SLTI:             alu = ($signed(op_a) < $signed(idex_q.imm)) ? 32'd1 : 32'd0;
      default:             alu = 32'd0;
    endcase
    br_taken = ex_valid & (((idex_q.op == OP_BNEQZ) & (op_a != 32'd0)) |
                           ((idex_q.op == OP_BEQZ) & (op_a == 32'd0)));
    exmem_d       = '0;
    exmem_d.valid = ex_valid;
    exmem_d.ld    = idex_q.op == OP_LW;
    exmem_d.st    = idex_q.op == OP_SW;
    exmem_d.halt  = idex_q.halt;
    exmem_d.wr    = idex_q.wr;
    exmem_d.dst   = idex_q.dst;
    exmem_d.alu   = alu;
    exmem_d.sd    = op_b;

    id_op = ifid_q.ir[31:26];
    id_rs = ifid_q.ir[25:21];
    id_rt = ifid_q.ir[20:16];
    id_rd = ifid_q.ir[15:11];
    is_rr = id_op <= OP_MUL;
    is_ri = (id_op == OP_ADDI) | (id_op == OP_SUBI) | (id_op == OP_SLTI);
    is_lw = id_op == OP_LW;
    is_sw = id_op == OP_SW;
    is_br = (id_op == OP_BNEQZ) | (id_op == OP_BEQZ);
    idex_d       = '0;
    idex_d.valid = ifid_q.valid & ~br_taken;
    idex_d.op    = id_op;
    idex_d.rs    = id_rs;
    idex_d.rt    = id_rt;
    idex_d.dst   = is_rr ? id_rd : id_rt;
    idex_d.wr    = is_rr | is_ri | is_lw;
    idex_d.halt  = ~(is_rr | is_ri | is_lw | is_sw | is_br);
    idex_d.imm   = {{16{ifid_q.ir[15]}}, ifid_q.ir[15:0]};
    idex_d.npc   = ifid_q.npc;
    idex_d.a     = (id_rs == 5'd0) ? 32'd0 :
                   (wb_we && memwb_q.dst == id_rs) ? memwb_q.val : Reg[id_rs];
    idex_d.b     = (id_rt == 5'd0) ? 32'd0 :
                   (wb_we && memwb_q.dst == id_rt) ? memwb_q.val : Reg[id_rt];

    ifid_d.valid = ~br_taken;
    ifid_d.ir    = Mem[PC[9:0]];
    ifid_d.npc   = PC + 32'd1;
    pc_d         = br_taken ? (idex_q.npc + idex_q.imm) : (PC + 32'd1);
    taken_d      = br_taken;

    if (HALTED) begin
      pc_d    = PC;
      taken_d = 1'b0;
      ifid_d  = ifid_q;
      idex_d  = idex_q;
      exmem_d = exmem_q;
      memwb_d = memwb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= 32'd0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      ifid_q       <= '0;
      idex_q       <= '0;
      exmem_q      <= '0;
      memwb_q      <= '0;
    end else begin
      PC           <= pc_d;
      HALTED       <= halted_d;
      TAKEN_BRANCH <= taken_d;
      ifid_q       <= ifid_d;
      idex_q       <= idex_d;
      exmem_q      <= exmem_d;
      memwb_q      <= memwb_d;
    end
  end

  // Register file and memory keep their contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) Mem[mem_addr] <= exmem_q.sd;
    if (wb_we) Reg[memwb_q.dst] <= memwb_q.val;
  end
endmodule

// File: tb/tb_mips_pipeline.sv
// tb/tb_mips_pipeline.sv - self-checking bench for mips_pipeline
module tb_mips_pipeline;
  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011;
  localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001;
  localparam logic [5:0] ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100;
  localparam logic [5:0] BNEQZ = 6'b001101, BEQZ = 6'b001110;
  localparam logic [31:0] HLT = 32'hfc000000;
  localparam logic [31:0] SENT = 32'hdeadbeef;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_pipeline dut (.clk(clk), .rst_n(rst_n));

  typedef struct { string name; bit is_mem; int idx; logic [31:0] exp; } chk_t;
  typedef struct { string name; logic [31:0] ins; int dst; logic [31:0] exp; } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  chk_t sb[$];
  logic [31:0] prog[$];
  logic [31:0] fact[11] = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000,
                            32'h0e94a000, 32'h14431000, 32'h2c630001, 32'h0e94a000,
                            32'h3460fffc, 32'h2542fffe, 32'hdc000000};

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_reg(input string name, input int r, input logic [31:0] v);
    sb.push_back('{name, 1'b0, r, v});
  endtask

  task automatic exp_mem(input string name, input int a, input logic [31:0] v);
    sb.push_back('{name, 1'b1, a, v});
  endtask

  task automatic drain();
    chk_t c;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      check(c.name, c.is_mem ? dut.Mem[c.idx] : dut.Reg[c.idx], c.exp);
    end
  endtask

  task automatic load(input logic [31:0] r0val);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
    for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
    dut.Reg[0] = r0val;
    for (int i = 0; i < prog.size(); i++) dut.Mem[i] = prog[i];
  endtask

  task automatic run(input int budget, output int cycles, output int taken, output int chg);
    logic [31:0] last;
    last = dut.Mem[198];
    cycles = 0; taken = 0; chg = 0;
    while (dut.HALTED !== 1'b1 && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (dut.TAKEN_BRANCH === 1'b1) taken++;
      if (dut.Mem[198] !== last) begin
        chg++;
        last = dut.Mem[198];
      end
    end
  endtask

  task automatic release_run(input int budget, output int cycles, output int taken, output int chg);
    @(negedge clk);
    rst_n = 1'b1;
    run(budget, cycles, taken, chg);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[13];
    int cyc, tk, chg;

    tab[0]  = '{"addi_r1",   ri(ADDI, 1, 0, 10),  1,  32'd10};
    tab[1]  = '{"addi_r2",   ri(ADDI, 2, 0, 20),  2,  32'd20};
    tab[2]  = '{"add_fwd",   rr(ADD, 3, 1, 2),    3,  32'd30};
    tab[3]  = '{"slt_true",  rr(SLT, 4, 1, 2),    4,  32'd1};
    tab[4]  = '{"sub_neg",   rr(SUB, 5, 1, 2),    5,  32'hfffffff6};
    tab[5]  = '{"and",       rr(AND_, 6, 3, 2),   6,  32'h14};
    tab[6]  = '{"or",        rr(OR_, 7, 5, 1),    7,  32'hfffffffe};
    tab[7]  = '{"mul_neg",   rr(MUL, 8, 5, 2),    8,  32'hffffff38};
    tab[8]  = '{"slti_sgn",  ri(SLTI, 9, 5, -5),  9,  32'd1};
    tab[9]  = '{"subi",      ri(SUBI, 10, 1, 11), 10, 32'hffffffff};
    tab[10] = '{"slt_false", rr(SLT, 11, 2, 5),   11, 32'd0};
    tab[11] = '{"addi_wrap", ri(ADDI, 12, 10, 1), 12, 32'd0};
    tab[12] = '{"mul_sq",    rr(MUL, 13, 5, 5),   13, 32'd100};

    // ALU, forwarding, load/store and branch sequence
    prog = {};
    foreach (tab[i]) begin
      prog.push_back(tab[i].ins);
      exp_reg(tab[i].name, tab[i].dst, tab[i].exp);
    end
    prog.push_back(ri(SW, 3, 0, 300));
    prog.push_back(ri(LW, 14, 0, 300));
    prog.push_back(32'd0);
    prog.push_back(rr(ADD, 15, 14, 14));
    prog.push_back(ri(SW, 15, 0, 301));
    prog.push_back(ri(SW, 7, 0, 1524));
    prog.push_back(ri(LW, 16, 0, 500));
    prog.push_back(ri(BEQZ, 0, 0, 2));
    prog.push_back(ri(ADDI, 17, 0, 1));
    prog.push_back(ri(ADDI, 18, 0, 1));
    prog.push_back(ri(ADDI, 19, 0, 4));
    prog.push_back(ri(BNEQZ, 0, 0, 5));
    prog.push_back(ri(ADDI, 20, 1, 7));
    prog.push_back(HLT);
    exp_reg("lw", 14, 32'd30);
    exp_reg("load_fwd", 15, 32'd60);
    exp_reg("lw_after_sw", 16, 32'hfffffffe);
    exp_reg("beqz_sq1", 17, 32'd17);
    exp_reg("beqz_sq2", 18, 32'd18);
    exp_reg("beqz_tgt", 19, 32'd4);
    exp_reg("bneqz_nt", 20, 32'd17);
    exp_mem("sw", 300, 32'd30);
    exp_mem("sw_fwd", 301, 32'd60);
    exp_mem("sw_wrap", 500, 32'hfffffffe);
    load(32'd0);
    release_run(200, cyc, tk, chg);
    check("alu_halted", 32'(dut.HALTED), 32'd1);
    check("alu_taken", 32'(tk), 32'd1);
    drain();

    // factorial and squash
    prog = {};
    foreach (fact[i]) prog.push_back(fact[i]);
    load(32'd0);
    dut.Mem[200] = 32'd7;
    dut.Mem[198] = SENT;
    exp_mem("fact_mem198", 198, 32'd5040);
    exp_reg("fact_r2", 2, 32'd5040);
    exp_reg("fact_r3", 3, 32'd0);
    exp_mem("fact_mem200", 200, 32'd7);
    release_run(100, cyc, tk, chg);
    check("fact_halted", 32'(dut.HALTED), 32'd1);
    check("fact_taken", 32'(tk), 32'd6);
    check("fact_sw_once", 32'(chg), 32'd1);
    drain();

    // R0 and halt freeze
    prog = {};
    prog.push_back(ri(ADDI, 0, 0, 5));
    prog.push_back(ri(ADDI, 7, 0, 3));
    prog.push_back(HLT);
    prog.push_back(ri(SW, 7, 0, 400));
    prog.push_back(ri(ADDI, 6, 0, 1));
    prog.push_back(ri(ADDI, 8, 0, 9));
    load(32'h55);
    exp_reg("r0_read", 7, 32'd3);
    exp_reg("r0_nowrite", 0, 32'h55);
    exp_reg("young_r6", 6, 32'd6);
    exp_reg("young_r8", 8, 32'd8);
    exp_mem("young_sw", 400, 32'd0);
    release_run(50, cyc, tk, chg);
    check("hlt_halted", 32'(dut.HALTED), 32'd1);
    check("hlt_cycles", 32'(cyc), 32'd7);
    check("hlt_pc", dut.PC, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    check("hlt_pc_frozen", dut.PC, 32'd7);
    check("hlt_still", 32'(dut.HALTED), 32'd1);
    drain();

    // reset mid-run, then restart
    prog = {};
    foreach (fact[i]) prog.push_back(fact[i]);
    load(32'd0);
    dut.Mem[200] = 32'd7;
    release_run(30, cyc, tk, chg);
    check("mid_not_halted", 32'(dut.HALTED), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_pc", dut.PC, 32'd0);
    check("rst_halted", 32'(dut.HALTED), 32'd0);
    check("rst_taken", 32'(dut.TAKEN_BRANCH), 32'd0);
    check("rst_mem200", dut.Mem[200], 32'd7);
    repeat (3) @(negedge clk);
    check("rst_pc_hold", dut.PC, 32'd0);
    dut.Mem[198] = SENT;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("restart_pc", dut.PC, 32'd1);
    exp_mem("re_mem198", 198, 32'd5040);
    exp_reg("re_r2", 2, 32'd5040);
    exp_mem("re_mem200", 200, 32'd7);
    run(100, cyc, tk, chg);
    check("re_halted", 32'(dut.HALTED), 32'd1);
    check("re_taken", 32'(tk), 32'd6);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
